hex_display_scheduler: RTL and testbench

- Shares the 4-digit HEX display bank between NREQ game requesters (score, timer, lives, ...).
- Round-robin arbiter grants one requester at a time. The granted binary value is latched, saturated to 9999 and converted to BCD by a sequential double-dabble engine (one shift per cycle).
- Resulting digits are held in output registers that feed the per-digit seg7 decoders, plus a leading-zero blank mask.
- Sits between game logic and the seg7 instances in the top level.

---
 rtl/hex_display_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_hex_display_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: round-robin owner of the 4-digit HEX display bank.
// A granted requester's value is saturated to 9999, converted to BCD by a
// one-shift-per-cycle double-dabble engine, and then published to the
// display registers together with a leading-zero blank mask.
module hex_display_scheduler #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   value,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic [15:0]             digits,
    output logic [3:0]              blank_mask,
    output logic [1:0]              owner,
    output logic                    ovf
);

    localparam int unsigned      CW      = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_BIN = WIDTH'(9999);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rr_q, rr_d;
    logic [1:0]       grant_q, grant_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_int_q, ovf_int_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       blank_q, blank_d;
    logic [1:0]       owner_q, owner_d;
    logic             ovf_q, ovf_d;

    logic             req_found;
    logic [1:0]       req_pick;
    logic [WIDTH-1:0] sel_value;
    logic [15:0]      bcd_adj;
    logic [15:0]      bcd_sh;
    logic [WIDTH-1:0] bin_sh;

    // Cyclic search: first requester at or above the rr pointer, else wrap to the lowest.
    always_comb begin
        req_found = 1'b0;
        req_pick  = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!req_found && req[j] && (j >= 32'(rr_q))) begin
                req_found = 1'b1;
                req_pick  = 2'(j);
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!req_found && req[j]) begin
                req_found = 1'b1;
                req_pick  = 2'(j);
            end
        end
    end

    // Select the granted requester's value slice.
    always_comb begin
        sel_value = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (grant_q == 2'(j)) begin
                sel_value = value[j*WIDTH +: WIDTH];
            end
        end
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned k = 0; k < 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        bcd_sh = {bcd_adj[14:0], bin_q[WIDTH-1]};
        bin_sh = {bin_q[WIDTH-2:0], 1'b0};
    end

    // Next-state and output-register logic for the IDLE/LOAD/SHIFT/DONE sequence.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        ack_d     = '0;
        digits_d  = digits_q;
        blank_d   = blank_q;
        owner_d   = owner_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_d = req_pick;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (sel_value > MAX_BIN) begin
                    bin_d     = MAX_BIN;
                    ovf_int_d = 1'b1;
                end else begin
                    bin_d     = sel_value;
                    ovf_int_d = 1'b0;
                end
                bcd_d   = '0;
                cnt_d   = CW'(WIDTH);
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d = bcd_sh;
                bin_d = bin_sh;
                cnt_d = cnt_q - CW'(1);
                // Display registers and ack are loaded on the edge entering DONE,
                // so they are visible during the DONE cycle together with ack.
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    digits_d = bcd_sh;
                    blank_d  = {bcd_sh[15:12] == 4'd0, bcd_sh[15:8] == 8'd0,
                                bcd_sh[15:4] == 12'd0, 1'b0};
                    owner_d  = grant_q;
                    ovf_d    = ovf_int_q;
                    for (int unsigned j = 0; j < NREQ; j++) begin
                        ack_d[j] = (grant_q == 2'(j));
                    end
                end
            end
            DONE: begin
                rr_d    = (grant_q == 2'(NREQ - 1)) ? 2'd0 : grant_q + 2'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            ack_q     <= '0;
            digits_q  <= '0;
            blank_q   <= 4'b1110;
            owner_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
            ack_q     <= ack_d;
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            owner_q   <= owner_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ack        = ack_q;
    assign busy       = (state_q != IDLE);
    assign digits     = digits_q;
    assign blank_mask = blank_q;
    assign owner      = owner_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Scoreboard bench for hex_display_scheduler: the driver pushes the predicted
// display update for every request; a monitor pops and compares on each ack.
module tb_hex_display_scheduler;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned WIDTH = 14;
    localparam int unsigned LAT   = WIDTH + 2;
    localparam int unsigned GAP   = WIDTH + 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] value;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [15:0]           digits;
    logic [3:0]            blank_mask;
    logic [1:0]            owner;
    logic                  ovf;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [15:0]     digits;
        logic [3:0]      blank;
        logic [1:0]      owner;
        logic            ovf;
        int unsigned     cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned model_rr = 0;
    int unsigned corner[11];

    hex_display_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req        (req),
        .value      (value),
        .ack        (ack),
        .busy       (busy),
        .digits     (digits),
        .blank_mask (blank_mask),
        .owner      (owner),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits of the saturated value by plain arithmetic.
    function automatic exp_t predict(input int unsigned v, input int unsigned who,
                                     input int unsigned at);
        exp_t e;
        int unsigned s;
        s = (v > 9999) ? 9999 : v;
        e.ack = '0;
        e.ack[who] = 1'b1;
        e.digits = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
        e.blank = {s < 1000, s < 100, s < 10, 1'b0};
        e.owner = 2'(who);
        e.ovf = (v > 9999);
        e.cyc = at;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_blank"}, 32'(blank_mask), 32'he);
        check({tag, "_owner"}, 32'(owner), 32'h0);
        check({tag, "_ovf"}, 32'(ovf), 32'h0);
        check({tag, "_ack"}, 32'(ack), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic set_value(input int unsigned who, input int unsigned v);
        value[who*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic wait_idle();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3 * GAP && busy; k++) begin
            @(posedge clk);
            #1;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy still 1, required 0 (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_ack(input int unsigned who);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 3 * GAP; k++) begin
            @(negedge clk);
            if (ack[who]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: no ack[%0d], required one within %0d cycles", who, 3 * GAP);
        end
    endtask

    task automatic run_txn(input int unsigned who, input int unsigned v,
                           input bit change, input int unsigned v2);
        wait_idle();
        set_value(who, v);
        req[who] = 1'b1;
        sb.push_back(predict(v, who, cyc + LAT));
        model_rr = (who + 1) % NREQ;
        if (change) begin
            repeat (5) @(posedge clk);
            #1;
            set_value(who, v2);
        end
        wait_ack(who);
        req[who] = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        req = '0;
        model_rr = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every ack must match the oldest outstanding prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ack !== '0) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: got ack=%b at cycle %0d, required none", ack, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack", 32'(ack), 32'(mon_e.ack));
                    check("ack_cycle", cyc, mon_e.cyc);
                    check("digits", 32'(digits), 32'(mon_e.digits));
                    check("blank_mask", 32'(blank_mask), 32'(mon_e.blank));
                    check("owner", 32'(owner), 32'(mon_e.owner));
                    check("ovf", 32'(ovf), 32'(mon_e.ovf));
                    check("busy_in_done", 32'(busy), 32'h1);
                end
            end
        end
    end

    initial begin
        int unsigned dv[2];
        int unsigned who;
        int unsigned n0;
        int          seen;

        corner[0] = 0;     corner[1] = 9;     corner[2] = 10;    corner[3] = 99;
        corner[4] = 100;   corner[5] = 999;   corner[6] = 1000;  corner[7] = 9998;
        corner[8] = 9999;  corner[9] = 10000; corner[10] = 16383;

        rst_n = 1'b0;
        req   = '0;
        value = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("after_reset");

        // Directed values from the test plan.
        run_txn(0, 1234, 1'b0, 0);
        run_txn(1, 7, 1'b0, 0);
        run_txn(0, 0, 1'b0, 0);
        run_txn(0, 16383, 1'b0, 0);
        run_txn(0, 9999, 1'b0, 0);
        run_txn(0, 10000, 1'b0, 0);
        run_txn(0, 55, 1'b1, 66);

        // Reset pulse in the middle of a conversion of 4321.
        wait_idle();
        set_value(0, 4321);
        req[0] = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        req = '0;
        model_rr = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2 * GAP) @(posedge clk);
        run_txn(0, 4321, 1'b0, 0);

        // Both requesters held: alternating service every GAP cycles.
        do_reset();
        wait_idle();
        dv[0] = $urandom_range(0, 16383);
        dv[1] = $urandom_range(0, 16383);
        set_value(0, dv[0]);
        set_value(1, dv[1]);
        req = '1;
        n0 = cyc;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(predict(dv[model_rr], model_rr, n0 + LAT + GAP * k));
            model_rr = (model_rr + 1) % NREQ;
        end
        seen = 0;
        for (int k = 0; k < 6 * GAP && seen < 4; k++) begin
            @(negedge clk);
            if (ack !== '0) seen++;
        end
        req = '0;
        if (seen < 4) begin
            tests++;
            fails++;
            $display("FAIL dual_timeout: got %0d acks, required 4", seen);
        end

        // Randomized single-requester traffic with corner values mixed in.
        for (int k = 0; k < 24; k++) begin
            who = $urandom_range(0, NREQ - 1);
            if ($urandom_range(0, 3) == 0) begin
                run_txn(who, corner[$urandom_range(0, 10)], 1'b0, 0);
            end else begin
                run_txn(who, $urandom_range(0, 16383), 1'b0, 0);
            end
        end

        repeat (2 * GAP) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
